// File: rtl/id_fwd_pkg.sv
// Shared decode constants for the ID/operand-forwarding stage.
// Contents: RV32 opcode and branch funct3 codes, immediate-format enum,
// immediate extraction and register-usage helpers.
package id_fwd_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // Immediate format implied by the opcode.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        imm_fmt_e fmt;
        fmt = IMM_I;
        case (opc)
            OPC_LUI, OPC_AUIPC:              fmt = IMM_U;
            OPC_JAL:                         fmt = IMM_J;
            OPC_BRANCH:                      fmt = IMM_B;
            OPC_STORE:                       fmt = IMM_S;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM:  fmt = IMM_I;
            default:                         fmt = IMM_I;
        endcase
        return fmt;
    endfunction

    // Sign-extended 32-bit immediate for the given format.
    function automatic logic [31:0] imm_ext(input imm_fmt_e fmt, input logic [INST_W-1:0] inst);
        logic [31:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
    endfunction

endpackage

// File: rtl/id_byp_sel.sv
// Priority bypass select for one source operand.
// Ports: rs (source index), rf_data (register-file read), byp_* (packed
// bypass channels, channel 0 youngest), data/pending (selected operand).
module id_byp_sel
    import id_fwd_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NBYP = 3
) (
    input  logic [REG_W-1:0]      rs,
    input  logic [XLEN-1:0]       rf_data,
    input  logic [NBYP-1:0]       byp_wen,
    input  logic [NBYP*REG_W-1:0] byp_rd,
    input  logic [NBYP*XLEN-1:0]  byp_data,
    input  logic [NBYP-1:0]       byp_pending,
    output logic [XLEN-1:0]       data,
    output logic                  pending
);

    // Walk oldest to youngest so the lowest-index match overrides the rest.
    always_comb begin
        data    = rf_data;
        pending = 1'b0;
        for (int i = int'(NBYP) - 1; i >= 0; i--) begin
            if (byp_wen[i] && (byp_rd[i*REG_W +: REG_W] == rs) && (rs != '0)) begin
                data    = byp_data[i*XLEN +: XLEN];
                pending = byp_pending[i];
            end
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode/operand stage: single instruction register, local register file,
// prioritised operand bypass with load interlock, branch/jump resolution
// with one-shot redirect and wrong-path squash, saturating perf counters.
// Ports: clk/reset (sync, active-high); in_* IF handshake; out_* EXE
// handshake with forwarded operands; byp_* bypass channels; rf_* writeback;
// redirect_* IF redirect; stall_cnt/redirect_cnt counters.
module id_fwd_stage
    import id_fwd_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned NBYP  = 3,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [INST_W-1:0]     in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [INST_W-1:0]     out_inst,
    output logic [XLEN-1:0]       out_rs1_data,
    output logic [XLEN-1:0]       out_rs2_data,
    output logic [REG_W-1:0]      out_rd,
    output logic                  out_rd_wen,
    input  logic [NBYP-1:0]       byp_wen,
    input  logic [NBYP*REG_W-1:0] byp_rd,
    input  logic [NBYP*XLEN-1:0]  byp_data,
    input  logic [NBYP-1:0]       byp_pending,
    input  logic                  rf_wen,
    input  logic [REG_W-1:0]      rf_waddr,
    input  logic [XLEN-1:0]       rf_wdata,
    output logic                  redirect_valid,
    output logic [XLEN-1:0]       redirect_pc,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      redirect_cnt
);

    // Bit i set when architectural register i exists.
    localparam logic [31:0] REG_MASK = 32'((64'd1 << NREG) - 64'd1);

    logic              valid;
    logic [XLEN-1:0]   pc_q;
    logic [INST_W-1:0] inst_q;
    logic [XLEN-1:0]   rf [32];

    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]  rf_rs1, rf_rs2, rs1_data, rs2_data, imm, jalr_sum;
    logic             pend1, pend2, hazard, br_taken, ctrl_taken;

    assign opc = inst_q[6:0];
    assign f3  = inst_q[14:12];
    assign rs1 = inst_q[19:15];
    assign rs2 = inst_q[24:20];
    assign rd  = inst_q[11:7];

    // Write-first read; x0 and non-existent registers read zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [REG_W-1:0] idx);
        if (idx == '0 || !REG_MASK[idx]) return '0;
        if (rf_wen && rf_waddr == idx)   return rf_wdata;
        return rf[idx];
    endfunction

    assign rf_rs1 = rf_read(rs1);
    assign rf_rs2 = rf_read(rs2);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (rf_wen && rf_waddr != '0 && REG_MASK[rf_waddr]) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    id_byp_sel #(.XLEN(XLEN), .NBYP(NBYP)) u_sel_rs1 (
        .rs(rs1), .rf_data(rf_rs1), .byp_wen(byp_wen), .byp_rd(byp_rd),
        .byp_data(byp_data), .byp_pending(byp_pending),
        .data(rs1_data), .pending(pend1)
    );

    id_byp_sel #(.XLEN(XLEN), .NBYP(NBYP)) u_sel_rs2 (
        .rs(rs2), .rf_data(rf_rs2), .byp_wen(byp_wen), .byp_rd(byp_rd),
        .byp_data(byp_data), .byp_pending(byp_pending),
        .data(rs2_data), .pending(pend2)
    );

    // Only a used operand whose winning source is still in flight interlocks.
    assign hazard    = valid && ((uses_rs1(opc) && pend1) || (uses_rs2(opc) && pend2));
    assign out_valid = valid && !hazard;
    assign in_ready  = !valid || (!hazard && out_ready);

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            F3_BEQ:  br_taken = (rs1_data == rs2_data);
            F3_BNE:  br_taken = (rs1_data != rs2_data);
            F3_BLT:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: br_taken = (rs1_data <  rs2_data);
            F3_BGEU: br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    assign imm        = XLEN'($signed(imm_ext(imm_fmt(opc), inst_q)));
    assign jalr_sum   = rs1_data + imm;
    assign ctrl_taken = (opc == OPC_BRANCH && br_taken) || (opc == OPC_JAL) || (opc == OPC_JALR);

    // Redirect only on the handshake cycle, so it fires once per instruction.
    assign redirect_valid = out_valid && out_ready && ctrl_taken;
    assign redirect_pc    = (opc == OPC_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm);

    assign out_pc       = pc_q;
    assign out_inst     = inst_q;
    assign out_rs1_data = rs1_data;
    assign out_rs2_data = rs2_data;
    assign out_rd       = rd;
    assign out_rd_wen   = (opc != OPC_BRANCH) && (opc != OPC_STORE) && (rd != '0);

    // A newly accepted instruction behind a redirect is wrong-path: drop it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (in_ready) begin
            valid <= in_valid && !redirect_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            pc_q   <= in_pc;
            inst_q <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (hazard && stall_cnt != '1)            stall_cnt    <= stall_cnt + CNT_W'(1);
            if (redirect_valid && redirect_cnt != '1) redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: directed scenarios followed by randomized
// instructions/bypass traffic checked against an in-bench reference model.
module tb_id_fwd_stage;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NBYP  = 3;
    localparam int CNT_W = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid, in_ready, out_valid, out_ready, out_rd_wen;
    logic [XLEN-1:0]     in_pc, out_pc, out_rs1_data, out_rs2_data, redirect_pc, rf_wdata;
    logic [31:0]         in_inst, out_inst;
    logic [4:0]          out_rd, rf_waddr;
    logic [NBYP-1:0]     byp_wen, byp_pending;
    logic [NBYP*5-1:0]   byp_rd;
    logic [NBYP*XLEN-1:0] byp_data;
    logic                rf_wen, redirect_valid;
    logic [CNT_W-1:0]    stall_cnt, redirect_cnt;

    id_fwd_stage #(.XLEN(XLEN), .NREG(NREG), .NBYP(NBYP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .byp_wen(byp_wen), .byp_rd(byp_rd), .byp_data(byp_data), .byp_pending(byp_pending),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef enum {K_ADD, K_BR, K_JAL, K_JALR, K_LUI, K_STORE} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        int          imm;
    } ins_t;

    int vectors = 0;
    int miscompares = 0;
    int exp_stall = 0;
    int exp_redir = 0;

    logic [31:0] m_rf [32];
    logic        c_wen [NBYP];
    logic [4:0]  c_rd [NBYP];
    logic [31:0] c_data [NBYP];
    logic        c_pend [NBYP];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ins_t mk(input kind_e k, input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] f3,
                                input int imm);
        ins_t x;
        x.kind = k; x.pc = pc; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.f3 = f3; x.imm = imm;
        return x;
    endfunction

    function automatic logic [31:0] enc(input ins_t x);
        logic [31:0] im, r;
        im = x.imm;
        case (x.kind)
            K_ADD:   r = {7'b0, x.rs2, x.rs1, 3'b000, x.rd, 7'b0110011};
            K_BR:    r = {im[12], im[10:5], x.rs2, x.rs1, x.f3, im[4:1], im[11], 7'b1100011};
            K_JAL:   r = {im[20], im[10:1], im[11], im[19:12], x.rd, 7'b1101111};
            K_JALR:  r = {im[11:0], x.rs1, 3'b000, x.rd, 7'b1100111};
            K_LUI:   r = {im[19:0], x.rd, 7'b0110111};
            default: r = {im[11:5], x.rs2, x.rs1, 3'b010, im[4:0], 7'b0100011};
        endcase
        return r;
    endfunction

    task automatic drive_byp();
        for (int i = 0; i < NBYP; i++) begin
            byp_wen[i]               = c_wen[i];
            byp_rd[i*5 +: 5]         = c_rd[i];
            byp_data[i*XLEN +: XLEN] = c_data[i];
            byp_pending[i]           = c_pend[i];
        end
    endtask

    task automatic set_ch(input int i, input logic w, input logic [4:0] r,
                          input logic [31:0] d, input logic p);
        c_wen[i] = w; c_rd[i] = r; c_data[i] = d; c_pend[i] = p;
        drive_byp();
    endtask

    task automatic clear_byp();
        for (int i = 0; i < NBYP; i++) begin
            c_wen[i] = 1'b0; c_rd[i] = '0; c_data[i] = '0; c_pend[i] = 1'b0;
        end
        drive_byp();
    endtask

    // Operand as the architecture sees it: youngest matching bypass, else RF (write-first).
    function automatic logic [31:0] m_read(input logic [4:0] rs, output logic pend);
        logic [31:0] v;
        logic        found;
        pend = 1'b0; found = 1'b0;
        v = m_rf[rs];
        if (rf_wen && rf_waddr == rs) v = rf_wdata;
        for (int i = 0; i < NBYP; i++) begin
            if (!found && c_wen[i] && c_rd[i] == rs) begin
                found = 1'b1; v = c_data[i]; pend = c_pend[i];
            end
        end
        if (rs == 5'd0) begin v = '0; pend = 1'b0; end
        return v;
    endfunction

    function automatic void model(input ins_t x, output logic [31:0] e1, output logic [31:0] e2,
                                  output logic u1, output logic u2, output logic haz,
                                  output logic ctl, output logic [31:0] tgt);
        logic p1, p2;
        logic [31:0] imv;
        imv = x.imm;
        e1 = m_read(x.rs1, p1);
        e2 = m_read(x.rs2, p2);
        u1 = (x.kind != K_LUI) && (x.kind != K_JAL);
        u2 = (x.kind == K_ADD) || (x.kind == K_BR) || (x.kind == K_STORE);
        haz = (u1 && p1) || (u2 && p2);
        ctl = 1'b0;
        tgt = x.pc + imv;
        case (x.kind)
            K_BR: case (x.f3)
                3'd0: ctl = (e1 == e2);
                3'd1: ctl = (e1 != e2);
                3'd4: ctl = ($signed(e1) < $signed(e2));
                3'd5: ctl = !($signed(e1) < $signed(e2));
                3'd6: ctl = (e1 < e2);
                3'd7: ctl = !(e1 < e2);
                default: ctl = 1'b0;
            endcase
            K_JAL: ctl = 1'b1;
            K_JALR: begin
                ctl = 1'b1;
                tgt = (e1 + imv) & 32'hFFFF_FFFE;
            end
            default: ctl = 1'b0;
        endcase
    endfunction

    // Present x with out_ready low and let it land in the stage.
    task automatic load(input ins_t x);
        in_valid = 1'b1; in_pc = x.pc; in_inst = enc(x); out_ready = 1'b0;
        #1;
        chk("load_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        exp_stall = 0;
        exp_redir = 0;
    endtask

    initial begin
        ins_t        x;
        logic [31:0] e1, e2, tgt;
        logic        u1, u2, haz, ctl, fired;
        logic [2:0]  f3s [6];

        f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        rf_wen = 1'b0; rf_waddr = '0; rf_wdata = '0;
        clear_byp();
        tick();
        do_reset();

        // Reset state
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_redirect", redirect_valid, 1'b0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_redir_cnt", redirect_cnt, 32'd0);
        tick();

        // Back-to-back ADDs, one per cycle, latency 1
        for (int k = 0; k < 4; k++) begin
            x = mk(K_ADD, 32'h100 + 32'(4 * k), 5'd1, 5'd2, 5'd3, 3'd0, 0);
            in_valid = (k < 3); in_pc = x.pc; in_inst = enc(x); out_ready = 1'b1;
            #1;
            chk("b2b_in_ready", in_ready, 1'b1);
            chk("b2b_out_valid", out_valid, (k > 0));
            if (k > 0) chk("b2b_out_pc", out_pc, 32'h100 + 32'(4 * (k - 1)));
            if (k == 1) chk("b2b_out_inst", out_inst, 32'h0020_81B3);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("b2b_drained", out_valid, 1'b0);
        chk("b2b_stall_cnt", stall_cnt, 32'd0);

        // Bypass priority: channel 0 beats channel 2; rs=0 ignores bypass
        load(mk(K_ADD, 32'h200, 5'd5, 5'd5, 5'd6, 3'd0, 0));
        set_ch(0, 1'b1, 5'd5, 32'h11, 1'b0);
        set_ch(2, 1'b1, 5'd5, 32'h22, 1'b0);
        #1;
        chk("prio_rs1", out_rs1_data, 32'h11);
        chk("prio_rs2", out_rs2_data, 32'h11);
        out_ready = 1'b1;
        tick();
        load(mk(K_ADD, 32'h204, 5'd0, 5'd0, 5'd6, 3'd0, 0));
        set_ch(0, 1'b1, 5'd0, 32'h11, 1'b0);
        set_ch(2, 1'b1, 5'd0, 32'h22, 1'b0);
        #1;
        chk("x0_rs1", out_rs1_data, 32'h0);
        chk("x0_rs2", out_rs2_data, 32'h0);
        out_ready = 1'b1;
        tick();
        clear_byp();

        // Load-use interlock on BEQ x7,x0, then redirect once data arrives
        load(mk(K_BR, 32'h300, 5'd7, 5'd0, 5'd0, 3'd0, 16));
        set_ch(0, 1'b1, 5'd7, 32'h5A5A, 1'b1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h304; in_inst = enc(mk(K_ADD, 32'h304, 5'd1, 5'd1, 5'd1, 3'd0, 0));
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_out_valid", out_valid, 1'b0);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_redirect", redirect_valid, 1'b0);
            tick();
        end
        exp_stall = 2;
        in_valid = 1'b0;
        set_ch(0, 1'b1, 5'd7, 32'h0, 1'b0);
        #1;
        chk("stall_cnt_2", stall_cnt, 32'(exp_stall));
        chk("beq_redirect", redirect_valid, 1'b1);
        chk("beq_target", redirect_pc, 32'h310);
        tick();
        exp_redir++;
        clear_byp();
        #1;
        chk("beq_one_shot", redirect_valid, 1'b0);
        chk("beq_empty", out_valid, 1'b0);

        // JALR held for 3 cycles: redirect only on the handshake cycle
        rf_wen = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'h1000;
        tick();
        m_rf[3] = 32'h1000;
        rf_wen = 1'b0;
        load(mk(K_JALR, 32'h400, 5'd3, 5'd0, 5'd1, 3'd0, 7));
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b0;
            #1;
            chk("jalr_hold_redirect", redirect_valid, 1'b0);
            chk("jalr_hold_valid", out_valid, 1'b1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("jalr_redirect", redirect_valid, 1'b1);
        chk("jalr_target", redirect_pc, 32'h1006);
        tick();
        exp_redir++;
        #1;
        chk("jalr_one_shot", redirect_valid, 1'b0);
        chk("jalr_redir_cnt", redirect_cnt, 32'(exp_redir));

        // Taken BNE squashes the instruction accepted in the same cycle
        load(mk(K_BR, 32'h500, 5'd3, 5'd0, 5'd0, 3'd1, -8));
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'h504; in_inst = enc(mk(K_ADD, 32'h504, 5'd1, 5'd2, 5'd3, 3'd0, 0));
        #1;
        chk("bne_redirect", redirect_valid, 1'b1);
        chk("bne_target", redirect_pc, 32'h4F8);
        chk("bne_in_ready", in_ready, 1'b1);
        tick();
        exp_redir++;
        in_valid = 1'b0;
        #1;
        chk("squash_out_valid", out_valid, 1'b0);
        chk("bne_redir_cnt", redirect_cnt, 32'(exp_redir));

        // Write-first RF read
        load(mk(K_ADD, 32'h600, 5'd9, 5'd0, 5'd10, 3'd0, 0));
        rf_wen = 1'b1; rf_waddr = 5'd9; rf_wdata = 32'hABCD;
        #1;
        chk("wfirst_rs1", out_rs1_data, 32'hABCD);
        chk("wfirst_rs2", out_rs2_data, 32'h0);
        out_ready = 1'b1;
        tick();
        m_rf[9] = 32'hABCD;
        rf_wen = 1'b0;
        load(mk(K_ADD, 32'h604, 5'd9, 5'd9, 5'd11, 3'd0, 0));
        #1;
        chk("rf_kept", out_rs2_data, 32'hABCD);
        out_ready = 1'b1;
        tick();

        // Reset in the middle of a stall
        load(mk(K_ADD, 32'h700, 5'd7, 5'd0, 5'd12, 3'd0, 0));
        set_ch(0, 1'b1, 5'd7, 32'h1, 1'b1);
        out_ready = 1'b1;
        #1;
        chk("mid_stall_valid", out_valid, 1'b0);
        tick();
        exp_stall++;
        chk("mid_stall_cnt", stall_cnt, 32'(exp_stall));
        do_reset();
        clear_byp();
        #1;
        chk("post_rst_valid", out_valid, 1'b0);
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_stall", stall_cnt, 32'd0);
        chk("post_rst_redir", redirect_cnt, 32'd0);
        load(mk(K_ADD, 32'h800, 5'd3, 5'd9, 5'd13, 3'd0, 0));
        #1;
        chk("post_rst_rf_x3", out_rs1_data, 32'h0);
        chk("post_rst_rf_x9", out_rs2_data, 32'h0);
        out_ready = 1'b1;
        tick();

        // Randomized instructions against the reference model
        for (int it = 0; it < 120; it++) begin
            x.kind = kind_e'($urandom_range(0, 5));
            x.pc   = $urandom & 32'hFFFF_FFFC;
            x.rs1  = 5'($urandom_range(0, 7));
            x.rs2  = 5'($urandom_range(0, 7));
            x.rd   = 5'($urandom_range(0, 31));
            x.f3   = f3s[$urandom_range(0, 5)];
            case (x.kind)
                K_BR:    x.imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                K_JAL:   x.imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                K_LUI:   x.imm = int'($urandom_range(0, 1048575));
                default: x.imm = int'($urandom_range(0, 4095)) - 2048;
            endcase
            clear_byp();
            rf_wen = 1'b0;
            load(x);

            for (int i = 0; i < NBYP; i++) begin
                c_wen[i] = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0:       c_rd[i] = x.rs1;
                    1:       c_rd[i] = x.rs2;
                    default: c_rd[i] = 5'($urandom_range(0, 7));
                endcase
                c_data[i] = $urandom;
                c_pend[i] = ($urandom_range(0, 3) == 0);
            end
            drive_byp();
            rf_wen = 1'($urandom_range(0, 1)); rf_waddr = 5'($urandom_range(0, 7)); rf_wdata = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            model(x, e1, e2, u1, u2, haz, ctl, tgt);
            chk("rnd_out_valid", out_valid, !haz);
            chk("rnd_in_ready", in_ready, !haz && out_ready);
            chk("rnd_redirect", redirect_valid, !haz && out_ready && ctl);
            chk("rnd_out_pc", out_pc, x.pc);
            chk("rnd_rd_wen", out_rd_wen,
                (x.kind != K_BR) && (x.kind != K_STORE) && (x.rd != 5'd0));
            if (u1) chk("rnd_rs1", out_rs1_data, e1);
            if (u2) chk("rnd_rs2", out_rs2_data, e2);
            if (!haz && ctl) chk("rnd_target", redirect_pc, tgt);
            if (rf_wen && rf_waddr != 5'd0) m_rf[rf_waddr] = rf_wdata;
            if (haz) exp_stall++;
            if (!haz && out_ready && ctl) exp_redir++;
            fired = !haz && out_ready;
            tick();
            rf_wen = 1'b0;

            if (!fired) begin
                for (int i = 0; i < NBYP; i++) c_pend[i] = 1'b0;
                drive_byp();
                out_ready = 1'b1;
                #1;
                model(x, e1, e2, u1, u2, haz, ctl, tgt);
                chk("rnd_drain_valid", out_valid, 1'b1);
                chk("rnd_drain_redirect", redirect_valid, ctl);
                if (u1) chk("rnd_drain_rs1", out_rs1_data, e1);
                if (ctl) chk("rnd_drain_target", redirect_pc, tgt);
                if (ctl) exp_redir++;
                tick();
            end
            chk("rnd_stall_cnt", stall_cnt, 32'(exp_stall));
            chk("rnd_redir_cnt", redirect_cnt, 32'(exp_redir));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
